// File: rtl/l1_scaler_bank.sv
// l1_scaler_bank
//   Per-channel L1 trigger scaler bank with a Wishbone target.
//   Running counters accumulate trigger pulses over a programmable gate.
//   At gate end all counts are copied into holding registers on one edge,
//   and the bus reads those holding registers.
//
// Ports
//   wb_clk_i              sole clock
//   wb_rst_i              synchronous active-high reset
//   trig_i[NCHAN]         synchronized trigger pulses, one count per high cycle
//   wb_cyc_i / wb_stb_i   Wishbone cycle / strobe
//   wb_we_i               write enable
//   wb_adr_i[12:0]        byte address; word index is wb_adr_i[12:2]
//   wb_dat_i[31:0]        write data
//   wb_sel_i[3:0]         byte selects; unused, all accesses are full-word
//   wb_ack_o              registered single-cycle acknowledge
//   wb_dat_o[31:0]        read data, valid with wb_ack_o, zero otherwise
//   wb_err_o / wb_rty_o   tied low
//
// Register map (byte address)
//   0x000 + 4n  latched scaler n (read-only)
//   0x100       CTRL: [0] ENABLE rw, [1] NEW ro sticky, [31:16] GATE_SEQ ro
//   0x104       PERIOD: gate length in clocks
module l1_scaler_bank #(
    parameter int unsigned NCHAN          = 8,
    parameter int unsigned SCALER_BITS    = 24,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd125000000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NCHAN-1:0] trig_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [12:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    output logic             wb_ack_o,
    output logic [31:0]      wb_dat_o,
    output logic             wb_err_o,
    output logic             wb_rty_o
);

    localparam logic [SCALER_BITS-1:0] CNT_MAX     = '1;
    localparam logic [10:0]            CTRL_WORD   = 11'h040;
    localparam logic [10:0]            PERIOD_WORD = 11'h041;

    logic [SCALER_BITS-1:0] cnt  [NCHAN];
    logic [SCALER_BITS-1:0] hold [NCHAN];
    logic [31:0]            tmr;
    logic [31:0]            period;
    logic                   enable;
    logic                   new_flag;
    logic [15:0]            gate_seq;

    logic [10:0] word;
    logic        accept;
    logic        terminal;
    logic        wr_cfg;
    logic        rd_ctrl;
    logic        clear_run;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign word     = wb_adr_i[12:2];
    assign accept   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign terminal = enable && (period != 32'd0) && (tmr == period - 32'd1);
    assign wr_cfg   = accept && wb_we_i && ((word == CTRL_WORD) || (word == PERIOD_WORD));
    assign rd_ctrl  = accept && !wb_we_i && (word == CTRL_WORD);

    // Any of these restarts the gate: counters and timer go to zero this edge.
    assign clear_run = !enable || (period == 32'd0) || terminal || wr_cfg;

    assign wb_err_o    = 1'b0;
    assign wb_rty_o    = 1'b0;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0]};

    function automatic logic [SCALER_BITS-1:0] sat_add(input logic [SCALER_BITS-1:0] v,
                                                       input logic inc);
        return (inc && (v != CNT_MAX)) ? v + SCALER_BITS'(1) : v;
    endfunction

    // Read mux sees pre-update state, so a read on a latch edge returns old data.
    always_comb begin
        rd_data = '0;
        if (word == CTRL_WORD) begin
            rd_data = {gate_seq, 14'b0, new_flag, enable};
        end else if (word == PERIOD_WORD) begin
            rd_data = period;
        end else begin
            for (int n = 0; n < NCHAN; n++) begin
                if (word == 11'(n)) begin
                    rd_data[SCALER_BITS-1:0] = hold[n];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            tmr      <= '0;
            period   <= DEFAULT_PERIOD;
            enable   <= 1'b0;
            new_flag <= 1'b0;
            gate_seq <= '0;
            for (int n = 0; n < NCHAN; n++) begin
                cnt[n]  <= '0;
                hold[n] <= '0;
            end
        end else begin
            wb_ack_o <= accept;
            wb_dat_o <= (accept && !wb_we_i) ? rd_data : 32'd0;

            tmr <= clear_run ? 32'd0 : tmr + 32'd1;

            // A pulse on the terminal cycle belongs to the gate being closed.
            for (int n = 0; n < NCHAN; n++) begin
                cnt[n] <= clear_run ? '0 : sat_add(cnt[n], trig_i[n]);
                if (terminal) begin
                    hold[n] <= sat_add(cnt[n], trig_i[n]);
                end
            end

            // Latch sets NEW even when a CTRL read is accepted on the same edge.
            if (terminal) begin
                new_flag <= 1'b1;
                gate_seq <= gate_seq + 16'd1;
            end else if (rd_ctrl) begin
                new_flag <= 1'b0;
            end

            if (accept && wb_we_i) begin
                if (word == CTRL_WORD) begin
                    enable <= wb_dat_i[0];
                end else if (word == PERIOD_WORD) begin
                    period <= wb_dat_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_l1_scaler_bank.sv
// Testbench for l1_scaler_bank (NCHAN=4, SCALER_BITS=4).
// Directed table and sequences plus randomized traffic, all compared every
// cycle against a behavioural model of the scaler bank.
module tb_l1_scaler_bank;

    localparam int NCH  = 4;
    localparam int SB   = 4;
    localparam int MAXV = 15;
    localparam logic [31:0] DEFP = 32'd125000000;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] trig;
    logic           cyc, stb, we;
    logic [12:0]    adr;
    logic [31:0]    wdat;
    logic [3:0]     sel;
    logic           ack, err, rty;
    logic [31:0]    dat;

    l1_scaler_bank #(
        .NCHAN       (NCH),
        .SCALER_BITS (SB),
        .DEFAULT_PERIOD (DEFP)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .trig_i   (trig),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_sel_i (sel),
        .wb_ack_o (ack),
        .wb_dat_o (dat),
        .wb_err_o (err),
        .wb_rty_o (rty)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int          m_cnt  [NCH];
    int          m_hold [NCH];
    logic [31:0] m_per, m_tmr, m_dat;
    bit          m_en, m_new, m_ack;
    int          m_gseq;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%08h exp=0x%08h", name, cyc_n, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_cnt[n]  = 0;
            m_hold[n] = 0;
        end
        m_per = DEFP; m_tmr = 0; m_en = 0; m_new = 0; m_gseq = 0;
        m_ack = 0; m_dat = 0;
    endtask

    // Predicts what the coming clock edge does given the inputs now applied.
    task automatic model_step();
        bit          acc, term, wrcfg, clr;
        int          w, sum;
        logic [31:0] rv;
        if (rst) begin
            model_reset();
            return;
        end
        acc = cyc && stb && !m_ack;
        w   = int'(adr[12:2]);
        if (w < NCH)       rv = m_hold[w];
        else if (w == 64)  rv = {m_gseq[15:0], 14'b0, m_new, m_en};
        else if (w == 65)  rv = m_per;
        else               rv = 0;
        term  = m_en && (m_per != 0) && (m_tmr == m_per - 1);
        wrcfg = acc && we && (w == 64 || w == 65);
        clr   = !m_en || (m_per == 0) || wrcfg || term;
        m_ack = acc;
        m_dat = (acc && !we) ? rv : 32'd0;
        for (int n = 0; n < NCH; n++) begin
            sum = m_cnt[n] + int'(trig[n]);
            if (sum > MAXV) sum = MAXV;
            if (term) m_hold[n] = sum;
            m_cnt[n] = clr ? 0 : sum;
        end
        m_tmr = clr ? 32'd0 : m_tmr + 1;
        if (term) begin
            m_new  = 1;
            m_gseq = (m_gseq + 1) % 65536;
        end else if (acc && !we && w == 64) begin
            m_new = 0;
        end
        if (acc && we && w == 64) m_en = wdat[0];
        if (acc && we && w == 65) m_per = wdat;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc_n++;
        check("ack", {31'b0, ack}, {31'b0, m_ack});
        check("rdata", dat, m_dat);
        check("err_rty", {30'b0, err, rty}, 32'd0);
    endtask

    task automatic access(input bit we_v, input logic [12:0] adr_v, input logic [31:0] dat_v,
                          output logic [31:0] rd);
        cyc = 1; stb = 1; we = we_v; adr = adr_v; wdat = dat_v;
        tick();
        rd = dat;
        cyc = 0; stb = 0; we = 0;
        tick();
    endtask

    typedef struct {
        bit          we;
        logic [12:0] adr;
        logic [31:0] wdat;
        logic [31:0] exp;
    } vec_t;

    vec_t        vt [10];
    logic [31:0] rd, g1, prev;
    int          ch;

    initial begin
        vt[0] = '{0, 13'h100, 32'h0, 32'h0000_0000};
        vt[1] = '{0, 13'h104, 32'h0, DEFP};
        vt[2] = '{0, 13'h000, 32'h0, 32'h0};
        vt[3] = '{0, 13'h00C, 32'h0, 32'h0};
        vt[4] = '{0, 13'h1FC, 32'h0, 32'h0};
        vt[5] = '{1, 13'h1FC, 32'hFFFF_FFFF, 32'h0};
        vt[6] = '{0, 13'h1FC, 32'h0, 32'h0};
        vt[7] = '{1, 13'h104, 32'h0000_1234, 32'h0};
        vt[8] = '{0, 13'h104, 32'h0, 32'h0000_1234};
        vt[9] = '{0, 13'h100, 32'h0, 32'h0000_0000};

        rst = 1; trig = 0; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 4'hF;
        repeat (3) tick();
        rst = 0;
        tick();

        // Reset values and address decode
        for (int i = 0; i < 10; i++) begin
            access(vt[i].we, vt[i].adr, vt[i].wdat, rd);
            if (!vt[i].we) check($sformatf("table%0d", i), rd, vt[i].exp);
        end

        // One 10-cycle gate with mixed pulses, ch1 only on the terminal cycle
        access(1, 13'h104, 32'd10, rd);
        access(1, 13'h100, 32'd1, rd);         // second tick of this is tmr=0
        for (int i = 1; i <= 9; i++) begin
            trig = 0;
            if (i >= 1 && i <= 3) trig[0] = 1;
            if (i >= 1 && i <= 7) trig[2] = 1;
            if (i == 9) trig[1] = 1;
            tick();
        end
        trig = 0;
        access(0, 13'h100, 0, rd); check("ctrl_first", rd, 32'h0001_0003);
        access(0, 13'h100, 0, rd); check("ctrl_second", rd, 32'h0001_0001);
        access(1, 13'h100, 32'd0, rd);
        access(0, 13'h000, 0, rd); check("hold0", rd, 32'd3);
        access(0, 13'h004, 0, rd); check("hold1", rd, 32'd1);
        access(0, 13'h008, 0, rd); check("hold2", rd, 32'd7);
        access(0, 13'h00C, 0, rd); check("hold3", rd, 32'd0);

        // Saturation: ch3 high for a whole 40-cycle gate
        trig = 4'b1000;
        access(1, 13'h104, 32'd40, rd);
        access(1, 13'h100, 32'd1, rd);
        repeat (39) tick();
        trig = 0;
        access(0, 13'h00C, 0, rd); check("sat_hold3", rd, 32'd15);
        access(1, 13'h100, 32'd0, rd);

        // PERIOD=0 freezes everything
        access(1, 13'h104, 32'd0, rd);
        access(1, 13'h100, 32'd1, rd);
        trig = 4'hF;
        repeat (100) tick();
        trig = 0;
        access(0, 13'h100, 0, rd); check("p0_ctrl", rd, 32'h0002_0003);
        access(0, 13'h00C, 0, rd); check("p0_hold3", rd, 32'd15);

        // PERIOD=1: every cycle latches that cycle's pulses
        access(1, 13'h104, 32'd1, rd);
        access(0, 13'h100, 0, g1);
        access(0, 13'h100, 0, rd);
        check("p1_gseq_step", {16'b0, rd[31:16] - g1[31:16]}, 32'd2);
        for (int i = 0; i < 8; i++) begin
            trig = 4'($urandom);
            tick();
            prev = {28'b0, trig};
            trig = 4'($urandom);
            ch = $urandom_range(0, NCH - 1);
            access(0, 13'(ch * 4), 0, rd);
            check("p1_latch", rd, {31'b0, prev[ch]});
        end
        trig = 0;

        // CTRL read accepted on the terminal edge sees NEW before the latch
        access(1, 13'h104, 32'd8, rd);
        access(0, 13'h100, 0, rd);            // clears NEW at tmr=1
        repeat (4) tick();
        access(0, 13'h100, 0, rd); check("new_pre_latch", rd & 32'h2, 32'h0);
        access(0, 13'h100, 0, rd); check("new_post_latch", rd & 32'h2, 32'h2);

        // Mid-gate PERIOD write discards counts in progress
        access(1, 13'h104, 32'd20, rd);
        trig = 4'b0001;
        repeat (3) tick();
        trig = 0;
        access(1, 13'h104, 32'd5, rd);        // second tick is tmr=0
        trig = 4'b0001;
        repeat (2) tick();
        trig = 0;
        repeat (2) tick();                    // tmr=3, tmr=4 (terminal)
        access(0, 13'h000, 0, rd); check("restart_hold0", rd, 32'd2);
        access(0, 13'h1FC, 0, rd); check("unmapped_rd", rd, 32'd0);
        access(1, 13'h1FC, 32'hDEAD_BEEF, rd);
        access(0, 13'h104, 0, rd); check("period_kept", rd, 32'd5);
        access(1, 13'h100, 32'd0, rd);

        // Randomized traffic, including back-to-back strobes and reset mid-access
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 499) == 0);
            trig = 4'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                cyc = 1;
                stb = ($urandom_range(0, 3) != 0);
                we  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 5))
                    0, 1:    adr = 13'($urandom_range(0, NCH - 1) * 4);
                    2:       adr = 13'h100;
                    3:       adr = ($urandom_range(0, 7) == 0) ? 13'h104 : 13'h100;
                    4:       adr = 13'h1FC;
                    default: adr = 13'($urandom);
                endcase
                if (adr[12:2] == 11'h041) wdat = $urandom_range(0, 12);
                else wdat = $urandom | {31'b0, ($urandom_range(0, 3) != 0)};
            end else begin
                cyc = 0; stb = 0; we = 0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_scaler_bank.md
# l1_scaler_bank

Wishbone-target scaler bank that sits directly downstream of the L1 trigger interconnect's scaler port. Counts per-channel L1 trigger pulses over a programmable gate period, latches all channels simultaneously at gate end, and serves latched values and control over a 13-bit-address, 32-bit-data Wishbone target. Runs entirely in the Wishbone clock domain; trigger pulses arrive already synchronized.

## Interface
Parameters:
- NCHAN, 8, number of trigger channels (1..32).
- SCALER_BITS, 24, width of each counter (1..32).
- DEFAULT_PERIOD, 32'd125000000, gate period in clocks after reset.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- trig_i  in  NCHAN  per-channel trigger pulses, one count per cycle high.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  13  byte address; word index = wb_adr_i[12:2].
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; ignored (full-word only).
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_dat_o  out  32  read data, valid with wb_ack_o.
- wb_err_o  out  1  tied 0.
- wb_rty_o  out  1  tied 0.

## Operation
- Register map (byte addr): 0x000+4n, n<NCHAN: latched scaler n, zero-extended, read-only. 0x100 CTRL: bit0 ENABLE (rw), bit1 NEW (ro, sticky), bits[31:16] GATE_SEQ (ro, gate counter, wraps 0xFFFF->0). 0x104 PERIOD (rw, 32 bits). All other addresses: read 0, writes ignored, still acked.
- Running counters cnt[n]: +1 when trig_i[n] high and ENABLE=1; saturate at 2^SCALER_BITS-1, never wrap.
- Gate timer tmr: counts 0..PERIOD-1 while ENABLE=1 and PERIOD!=0. Terminal cycle (tmr==PERIOD-1): hold[n] <= saturate(cnt[n] + trig_i[n]) for all n; cnt[n] <= 0; tmr <= 0; NEW <= 1; GATE_SEQ += 1. Pulse on terminal cycle counts in the closing gate.
- PERIOD=1: every cycle is terminal; hold[n] = trig_i[n] of that cycle.
- PERIOD=0: timer and counters held at 0; no latches; holds retain values.
- ENABLE=0: tmr and cnt cleared and held; holds, NEW, GATE_SEQ retained.
- Write to PERIOD or CTRL (any value): tmr and all cnt cleared same edge; new gate starts next cycle.
- Read of CTRL clears NEW on the ack edge, unless a terminal cycle occurs that same edge (set wins).
- Reset: cnt, hold, tmr, GATE_SEQ = 0; ENABLE=0; NEW=0; PERIOD=DEFAULT_PERIOD; wb_ack_o=0; wb_dat_o=0.

## Timing
- Access accepted when wb_cyc_i & wb_stb_i & !wb_ack_o. wb_ack_o registered, high exactly one cycle, the cycle after acceptance. Back-to-back strobes therefore ack every other cycle.
- wb_dat_o registered with ack; value is hold/CTRL/PERIOD as of acceptance edge (read at acceptance, pre-update). 0 when ack low.
- Writes take effect on acceptance edge; readback of written register valid on the next access.
- Latch is atomic: all NCHAN holds update on the same edge; a read accepted on that edge returns pre-latch value.
- Strobe dropped while ack pending: ack still issued; master ignores it. Reset mid-access: ack suppressed, registers to reset values.
- Latency trig_i -> visible in hold: up to PERIOD cycles plus 1.

## Test plan
- Reset, read 0x100 -> 0x00000000; read 0x104 -> DEFAULT_PERIOD; read 0x000 -> 0; ack one cycle after strobe.
- NCHAN=4, PERIOD=10, ENABLE=1; pulse ch0 3x, ch2 7x within one gate, ch1 once on terminal cycle -> holds {3,1,7,0}, CTRL reads 0x00010003; second CTRL read 0x00010001.
- SCALER_BITS=4, ch3 held high for 40 cycles with PERIOD=40 -> hold[3]=15 (saturated, no wrap).
- PERIOD=0 with trig_i all high for 100 cycles -> holds unchanged, GATE_SEQ unchanged; then PERIOD=1 -> each latch equals that cycle's trig_i, GATE_SEQ increments every cycle.
- CTRL read accepted on terminal-cycle edge -> returns NEW=0 pre-latch, NEW reads 1 afterwards.
- Write 5 to PERIOD mid-gate after 3 pulses on ch0 -> those counts discarded; next latch 5 cycles later reflects only subsequent pulses; read 0x1FC -> 0, write to it ignored, acked.
